// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour/placement types and screen geometry for the sprite path
package sprite_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] mirror;
      logic       enable;
   } sprite_cfg_t;
endpackage

// File: rtl/sprite_cfg_shadow.sv
// sprite_cfg_shadow: pending/active placement registers, committed only at frame start
module sprite_cfg_shadow
   import sprite_pkg::*;
(
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic        i_frame_start,
   input  logic        i_valid,
   input  sprite_cfg_t i_cfg,
   output logic        o_ready,
   output sprite_cfg_t o_cfg
);
   logic        r_pend;
   sprite_cfg_t r_pend_cfg;
   sprite_cfg_t r_act;
   logic        w_commit;

   assign w_commit = i_frame_start && r_pend;
   assign o_ready  = !r_pend;
   // the commit is forwarded so pixel (0,0) already uses the new placement
   assign o_cfg    = w_commit ? r_pend_cfg : r_act;

   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         r_pend     <= 1'b0;
         r_pend_cfg <= '0;
         r_act      <= '0;
      end else if (w_commit) begin
         r_act  <= r_pend_cfg;
         r_pend <= 1'b0;
      end else if (i_valid && !r_pend) begin
         r_pend     <= 1'b1;
         r_pend_cfg <= i_cfg;
      end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: positioned, power-of-two scaled, mirrorable sprite renderer for the VGA pixel path
module sprite_blitter
   import sprite_pkg::*;
#(
   parameter int               SPR_W_LOG2 = 5,
   parameter int               SPR_H_LOG2 = 5,
   parameter int               SCALE_LOG2 = 0,
   parameter int               IDX_W      = 4,
   parameter logic [IDX_W-1:0] TRANSP_IDX = '0,
   parameter logic [11:0]      BG_RGB     = 12'h000
) (
   input  logic                             vga_clk,
   input  logic                             reset_n,
   input  logic [9:0]                       DrawX,
   input  logic [9:0]                       DrawY,
   input  logic                             blank,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [9:0]                       cfg_x,
   input  logic [9:0]                       cfg_y,
   input  logic [1:0]                       cfg_mirror,
   input  logic                             cfg_enable,
   output logic [SPR_W_LOG2+SPR_H_LOG2-1:0] rom_addr,
   input  logic [IDX_W-1:0]                 rom_q,
   output logic [IDX_W-1:0]                 pal_idx,
   input  logic [3:0]                       pal_r,
   input  logic [3:0]                       pal_g,
   input  logic [3:0]                       pal_b,
   output logic [3:0]                       red,
   output logic [3:0]                       green,
   output logic [3:0]                       blue,
   output logic                             sprite_hit
);
   sprite_cfg_t             w_cfg_in;
   sprite_cfg_t             w_cfg;
   logic                    w_frame_start;
   logic                    w_inside;
   logic                    w_opaque;
   logic signed [10:0]      w_dx;
   logic signed [10:0]      w_dy;
   logic [SPR_W_LOG2-1:0]   w_tx;
   logic [SPR_H_LOG2-1:0]   w_ty;
   logic                    r_in1, r_in2, r_bl1, r_bl2;
   rgb444_t                 w_pix;
   rgb444_t                 r_pix;

   assign w_cfg_in      = '{x: cfg_x, y: cfg_y, mirror: cfg_mirror, enable: cfg_enable};
   assign w_frame_start = (DrawX == '0) && (DrawY == '0);

   sprite_cfg_shadow u_shadow (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .i_frame_start(w_frame_start),
      .i_valid      (cfg_valid),
      .i_cfg        (w_cfg_in),
      .o_ready      (cfg_ready),
      .o_cfg        (w_cfg)
   );

   assign w_dx = $signed({1'b0, DrawX}) - $signed({1'b0, w_cfg.x});
   assign w_dy = $signed({1'b0, DrawY}) - $signed({1'b0, w_cfg.y});
   // offsets below the scaled sprite size have no bits at or above the size exponent
   assign w_inside = w_cfg.enable && !w_dx[10] && !w_dy[10]
      && ((w_dx[9:0] >> (SPR_W_LOG2 + SCALE_LOG2)) == '0)
      && ((w_dy[9:0] >> (SPR_H_LOG2 + SCALE_LOG2)) == '0)
      && (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
   assign w_tx = w_dx[SCALE_LOG2 +: SPR_W_LOG2] ^ {SPR_W_LOG2{w_cfg.mirror[0]}};
   assign w_ty = w_dy[SCALE_LOG2 +: SPR_H_LOG2] ^ {SPR_H_LOG2{w_cfg.mirror[1]}};

   assign w_opaque = r_in2 && (rom_q != TRANSP_IDX);
   assign w_pix    = !r_bl2 ? rgb444_t'(12'h000) :
                     w_opaque ? rgb444_t'({pal_r, pal_g, pal_b}) : rgb444_t'(BG_RGB);

   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         rom_addr   <= '0;
         r_in1      <= 1'b0;
         r_bl1      <= 1'b0;
         r_in2      <= 1'b0;
         r_bl2      <= 1'b0;
         r_pix      <= '0;
         sprite_hit <= 1'b0;
      end else begin
         rom_addr   <= {w_ty, w_tx};
         r_in1      <= w_inside;
         r_bl1      <= blank;
         r_in2      <= r_in1;
         r_bl2      <= r_bl1;
         r_pix      <= w_pix;
         sprite_hit <= r_bl2 && w_opaque;
      end

   assign pal_idx = rom_q;
   assign red     = r_pix.r;
   assign green   = r_pix.g;
   assign blue    = r_pix.b;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: random beam/placement stimulus checked against a behavioural sprite model
module tb_sprite_blitter;
   import sprite_pkg::*;
   localparam int MAXN = 8192;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [9:0] DrawX = '0, DrawY = '0, cfg_x = '0, cfg_y = '0;
   logic       blank = 1'b0, cfg_valid = 1'b0, cfg_enable = 1'b0;
   logic [1:0] cfg_mirror = '0;
   logic       rdy0, rdy1, hit0, hit1;
   logic [9:0] addr0, addr1;
   logic [3:0] q0 = '0, q1 = '0, pidx0, pidx1;
   logic [3:0] r0, g0, b0, r1, g1, b1;
   logic [11:0] palc0, palc1;
   logic [3:0] rom [1024];

   logic [11:0] rgb_o [2];
   logic        hit_o [2];
   logic        rdy_o [2];
   logic [9:0]  addr_o [2];

   int vectors = 0, errors = 0;
   int napplied = 0, base = 0, ci, cj;
   bit chk_on = 0;
   sprite_cfg_t act = '0, pend_cfg = '0, nc = '0;
   bit pend = 0;
   logic [11:0] e_rgb  [2][MAXN];
   bit          e_hit  [2][MAXN];
   bit          e_in   [2][MAXN];
   int          e_addr [2][MAXN];

   always #5 vga_clk = ~vga_clk;

   function automatic logic [11:0] pal(input logic [3:0] i);
      return {i, i ^ 4'hA, ~i};
   endfunction

   assign palc0 = pal(pidx0);
   assign palc1 = pal(pidx1);
   assign rgb_o[0] = {r0, g0, b0};
   assign rgb_o[1] = {r1, g1, b1};
   assign hit_o[0] = hit0;
   assign hit_o[1] = hit1;
   assign rdy_o[0] = rdy0;
   assign rdy_o[1] = rdy1;
   assign addr_o[0] = addr0;
   assign addr_o[1] = addr1;

   sprite_blitter u_dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_x(cfg_x), .cfg_y(cfg_y),
      .cfg_mirror(cfg_mirror), .cfg_enable(cfg_enable), .rom_addr(addr0), .rom_q(q0),
      .pal_idx(pidx0), .pal_r(palc0[11:8]), .pal_g(palc0[7:4]), .pal_b(palc0[3:0]),
      .red(r0), .green(g0), .blue(b0), .sprite_hit(hit0)
   );

   sprite_blitter #(.SCALE_LOG2(1)) u_dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_x(cfg_x), .cfg_y(cfg_y),
      .cfg_mirror(cfg_mirror), .cfg_enable(cfg_enable), .rom_addr(addr1), .rom_q(q1),
      .pal_idx(pidx1), .pal_r(palc1[11:8]), .pal_g(palc1[7:4]), .pal_b(palc1[3:0]),
      .red(r1), .green(g1), .blue(b1), .sprite_hit(hit1)
   );

   always @(posedge vga_clk) begin
      q0 <= rom[addr0];
      q1 <= rom[addr1];
   end

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (iter %0d)", name, got, exp, napplied);
      end
   endtask

   function automatic sprite_cfg_t mk(input int x, input int y, input int m, input int e);
      return '{x: 10'(x), y: 10'(y), mirror: 2'(m), enable: 1'(e)};
   endfunction

   // reference: what each pixel must show, from placement, scale and ROM contents
   task automatic apply(input int x, input int y, input bit bl, input bit cv, input sprite_cfg_t c);
      sprite_cfg_t eff;
      bit fs;
      if (napplied >= MAXN) begin
         $display("FAIL model_overflow: got %0d expected below %0d", napplied, MAXN);
         $fatal(1);
      end
      fs  = (x == 0) && (y == 0);
      eff = (fs && pend) ? pend_cfg : act;
      for (int k = 0; k < 2; k++) begin
         int sz, dx, dy, tx, ty;
         bit in;
         logic [3:0] q;
         sz = 32 << k;
         dx = x - int'(eff.x);
         dy = y - int'(eff.y);
         in = eff.enable && dx >= 0 && dy >= 0 && dx < sz && dy < sz && x < 640 && y < 480;
         tx = in ? dx / (1 << k) : 0;
         ty = in ? dy / (1 << k) : 0;
         if (eff.mirror[0]) tx = 31 - tx;
         if (eff.mirror[1]) ty = 31 - ty;
         q = rom[ty * 32 + tx];
         e_in[k][napplied]   = in;
         e_addr[k][napplied] = ty * 32 + tx;
         e_hit[k][napplied]  = bl && in && q != 4'd0;
         e_rgb[k][napplied]  = !bl ? 12'h000 : (in && q != 4'd0) ? pal(q) : 12'h000;
      end
      if (fs && pend) begin
         act  = pend_cfg;
         pend = 0;
      end else if (cv && !pend) begin
         pend     = 1;
         pend_cfg = c;
      end
      DrawX = 10'(x); DrawY = 10'(y); blank = bl; cfg_valid = cv;
      cfg_x = c.x; cfg_y = c.y; cfg_mirror = c.mirror; cfg_enable = c.enable;
      napplied++;
   endtask

   task automatic step(input int x, input int y, input bit bl, input bit cv, input sprite_cfg_t c);
      apply(x, y, bl, cv, c);
      @(negedge vga_clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      blank = 1'b0;
      cfg_valid = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset_rgb%0d", k), int'(rgb_o[k]), 0);
         check($sformatf("reset_hit%0d", k), int'(hit_o[k]), 0);
         check($sformatf("reset_addr%0d", k), int'(addr_o[k]), 0);
         check($sformatf("reset_ready%0d", k), int'(rdy_o[k]), 1);
      end
      repeat (2) @(posedge vga_clk);
      #2;
      reset_n = 1'b1;
      pend = 0; act = '0; pend_cfg = '0;
      base = napplied;
      chk_on = 1;
   endtask

   always @(posedge vga_clk) begin
      #1;
      if (reset_n && chk_on) begin
         ci = napplied - 3;
         cj = napplied - 1;
         for (int k = 0; k < 2; k++) begin
            check($sformatf("ready%0d", k), int'(rdy_o[k]), int'(!pend));
            if (ci >= base) begin
               check($sformatf("rgb%0d", k), int'(rgb_o[k]), int'(e_rgb[k][ci]));
               check($sformatf("hit%0d", k), int'(hit_o[k]), int'(e_hit[k][ci]));
            end else begin
               check($sformatf("flush_rgb%0d", k), int'(rgb_o[k]), 0);
               check($sformatf("flush_hit%0d", k), int'(hit_o[k]), 0);
            end
            if (cj >= base && e_in[k][cj])
               check($sformatf("addr%0d", k), int'(addr_o[k]), e_addr[k][cj]);
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 15));
      rom[0] = 4'd0;
      rom[1] = 4'd5;
      #3;
      do_reset();
      @(negedge vga_clk);
      repeat (4) step(300, 200, 1, 0, nc);
      step(5, 5, 1, 1, mk(100, 50, 0, 1));
      check("ready_pending", int'(rdy0), 0);
      step(10, 10, 1, 0, nc);
      check("ready_hold", int'(rdy0), 0);
      step(0, 0, 1, 0, nc);
      check("ready_after_frame", int'(rdy0), 1);
      step(100, 50, 1, 0, nc);
      check("addr_origin", int'(addr0), 0);
      step(131, 81, 1, 0, nc);
      check("addr_corner", int'(addr0), 1023);
      step(102, 50, 1, 0, nc);
      check("addr_scaled", int'(addr1), 1);
      step(164, 50, 1, 0, nc);
      step(101, 50, 1, 0, nc);
      step(100, 50, 1, 0, nc);
      check("scaled_outside_rgb", int'(rgb_o[1]), 12'h000);
      check("scaled_outside_hit", int'(hit1), 0);
      step(101, 50, 0, 0, nc);
      check("opaque_rgb", int'(rgb_o[0]), 12'h5FA);
      check("opaque_hit", int'(hit0), 1);
      step(300, 300, 1, 0, nc);
      check("transp_rgb", int'(rgb_o[0]), 12'h000);
      check("transp_hit", int'(hit0), 0);
      step(300, 300, 1, 0, nc);
      check("blank_rgb", int'(rgb_o[0]), 12'h000);
      check("blank_hit", int'(hit0), 0);
      step(7, 7, 1, 1, mk(100, 50, 1, 1));
      step(0, 0, 1, 0, nc);
      step(100, 50, 1, 0, nc);
      check("addr_mirror_x", int'(addr0), 31);
      step(7, 7, 1, 1, mk(100, 50, 2, 1));
      step(0, 0, 1, 0, nc);
      step(100, 50, 1, 0, nc);
      check("addr_flip_y", int'(addr0), 992);
      step(7, 7, 1, 1, mk(620, 50, 0, 1));
      step(0, 0, 1, 0, nc);
      step(621, 50, 1, 0, nc);
      check("addr_right_edge", int'(addr0), 1);
      step(639, 51, 1, 0, nc);
      step(0, 51, 1, 0, nc);
      step(1, 51, 1, 0, nc);
      step(2, 51, 1, 0, nc);
      check("no_wrap_hit", int'(hit0), 0);
      step(110, 60, 1, 0, nc);
      do_reset();
      @(negedge vga_clk);
      for (int n = 0; n < 3000; n++) begin
         int r, x, y;
         sprite_cfg_t c;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            x = 0; y = 0;
         end else if (r < 60) begin
            x = int'(act.x) + int'($urandom_range(0, 80)) - 8;
            y = int'(act.y) + int'($urandom_range(0, 80)) - 8;
            x = x < 0 ? 0 : x > 639 ? 639 : x;
            y = y < 0 ? 0 : y > 479 ? 479 : y;
         end else begin
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 479));
         end
         c = mk(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 9) != 0));
         step(x, y, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 6, c);
         if (n == 1500) begin
            do_reset();
            @(negedge vga_clk);
         end
      end
      repeat (4) step(300, 300, 0, 0, nc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
